// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer for the snake datapath.
// Paces the snake with a move tick and arbitrates the direction buttons into one
// heading per move. Places food with an LFSR and checks each move for walls,
// self-hits and eating. Flow: IDLE -> PLACE -> RUN -> (PLACE | OVER).
module snake_game_ctrl #(
    parameter int          TICK_DIV   = 30000000,
    parameter int          BOX_SIZE   = 5,
    parameter int          X_MAX      = 800,
    parameter int          Y_MAX      = 600,
    parameter int          MAX_LENGTH = 50,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        right,
    input  logic        left,
    input  logic        down,
    input  logic        up,
    input  logic [10:0] head_x,
    input  logic [9:0]  head_y,
    input  logic        self_hit,
    input  logic [5:0]  snake_length,
    output logic [1:0]  dir,
    output logic        move_tick,
    output logic        grow,
    output logic [10:0] food_x,
    output logic [9:0]  food_y,
    output logic        game_over,
    output logic [7:0]  score,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLACE = 2'd1,
        ST_RUN   = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [15:0]       SEED     = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [10:0]       BOX_X    = 11'(BOX_SIZE);
    localparam logic [9:0]        BOX_Y    = 10'(BOX_SIZE);
    localparam logic [10:0]       X_LIM    = 11'(X_MAX);
    localparam logic [9:0]        Y_LIM    = 10'(Y_MAX);
    localparam logic [8:0]        X_CELLS  = 9'(X_MAX / BOX_SIZE);
    localparam logic [7:0]        Y_CELLS  = 8'(Y_MAX / BOX_SIZE);
    localparam logic [6:0]        MAX_LEN  = 7'(MAX_LENGTH);
    localparam logic [10:0]       FOOD_X0  = 11'd400;
    localparam logic [9:0]        FOOD_Y0  = 10'd300;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              tick_pend_reg, tick_pend_next;
    logic [1:0]        pend_reg, pend_next;
    logic [1:0]        dir_reg, dir_next;
    logic              move_tick_reg, move_tick_next;
    logic              grow_reg, grow_next;
    logic              check_reg, check_next;
    logic [10:0]       food_x_reg, food_x_next;
    logic [9:0]        food_y_reg, food_y_next;
    logic [7:0]        score_reg, score_next;
    logic [15:0]       lfsr_reg, lfsr_next;

    // Buttons indexed by their direction code: r=0, u=1, d=2, l=3
    logic [3:0]  btn;
    logic [3:0]  btn_ok;
    assign btn = {left, down, up, right};

    // A press is usable only if it does not reverse the current heading
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            localparam logic [1:0] CODE = 2'(gi);
            assign btn_ok[gi] = btn[gi] && (CODE != ~dir_reg);
        end
    endgenerate

    // Priority up > down > right > left among the presses offered
    function automatic logic [1:0] pick_dir(input logic [3:0] b);
        if (b[1])      return 2'd1;
        else if (b[2]) return 2'd2;
        else if (b[0]) return 2'd0;
        else           return 2'd3;
    endfunction

    logic [15:0] lfsr_step;
    logic [7:0]  xi;
    logic [6:0]  yi;
    logic [10:0] cand_x;
    logic [9:0]  cand_y;
    logic        cand_ok;
    logic        cnt_last;
    logic        wall;
    logic        eat;

    assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign xi        = lfsr_reg[7:0];
    assign yi        = lfsr_reg[14:8];
    assign cand_x    = ({3'b000, xi} + 11'd1) * BOX_X;
    assign cand_y    = ({3'b000, yi} + 10'd1) * BOX_Y;
    assign cand_ok   = ({1'b0, xi} < X_CELLS) && ({1'b0, yi} < Y_CELLS) &&
                       ((cand_x != head_x) || (cand_y != head_y));
    assign cnt_last  = (cnt_reg == CNT_LAST);
    assign wall      = (head_x > X_LIM) || (head_x < BOX_X) || (head_y > Y_LIM) || (head_y < BOX_Y);
    assign eat       = (head_x == food_x_reg) && (head_y == food_y_reg);

    // Next-state logic: game flow, move pacing, food placement and move checking
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        tick_pend_next = tick_pend_reg;
        pend_next      = pend_reg;
        dir_next       = dir_reg;
        move_tick_next = 1'b0;
        grow_next      = 1'b0;
        check_next     = move_tick_reg;
        food_x_next    = food_x_reg;
        food_y_next    = food_y_reg;
        score_next     = score_reg;
        lfsr_next      = lfsr_reg;

        if ((state_reg == ST_PLACE || state_reg == ST_RUN) && (|btn_ok))
            pend_next = pick_dir(btn_ok);

        case (state_reg)
            ST_IDLE: begin
                cnt_next       = '0;
                tick_pend_next = 1'b0;
                if (|btn) begin
                    pend_next  = pick_dir(btn);
                    state_next = ST_PLACE;
                end
            end
            ST_PLACE: begin
                lfsr_next = lfsr_step;
                cnt_next  = cnt_last ? '0 : cnt_reg + CNT_ONE;
                // A tick falling due here is remembered and issued on entry to RUN
                if (cnt_last)
                    tick_pend_next = 1'b1;
                if (cand_ok) begin
                    food_x_next = cand_x;
                    food_y_next = cand_y;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_last ? '0 : cnt_reg + CNT_ONE;
                if (cnt_last || tick_pend_reg) begin
                    move_tick_next = 1'b1;
                    dir_next       = pend_reg;
                    tick_pend_next = 1'b0;
                end
                // Head is valid the cycle after move_tick; collision beats eating
                if (check_reg) begin
                    if (wall || self_hit) begin
                        state_next = ST_OVER;
                    end else if (eat) begin
                        if (score_reg != 8'hFF)
                            score_next = score_reg + 8'd1;
                        grow_next  = ({1'b0, snake_length} < MAX_LEN);
                        state_next = ST_PLACE;
                    end
                end
            end
            ST_OVER: begin
                check_next = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A new-game request clears everything except the LFSR
        if (restart) begin
            state_next     = ST_IDLE;
            cnt_next       = '0;
            tick_pend_next = 1'b0;
            pend_next      = 2'd0;
            dir_next       = 2'd0;
            move_tick_next = 1'b0;
            grow_next      = 1'b0;
            check_next     = 1'b0;
            food_x_next    = FOOD_X0;
            food_y_next    = FOOD_Y0;
            score_next     = 8'd0;
            lfsr_next      = lfsr_reg;
        end
    end

    // State and output registers; reset also reloads the LFSR seed
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            tick_pend_reg <= 1'b0;
            pend_reg      <= 2'd0;
            dir_reg       <= 2'd0;
            move_tick_reg <= 1'b0;
            grow_reg      <= 1'b0;
            check_reg     <= 1'b0;
            food_x_reg    <= FOOD_X0;
            food_y_reg    <= FOOD_Y0;
            score_reg     <= 8'd0;
            lfsr_reg      <= SEED;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            tick_pend_reg <= tick_pend_next;
            pend_reg      <= pend_next;
            dir_reg       <= dir_next;
            move_tick_reg <= move_tick_next;
            grow_reg      <= grow_next;
            check_reg     <= check_next;
            food_x_reg    <= food_x_next;
            food_y_reg    <= food_y_next;
            score_reg     <= score_next;
            lfsr_reg      <= lfsr_next;
        end
    end

    assign dir       = dir_reg;
    assign move_tick = move_tick_reg;
    assign grow      = grow_reg;
    assign food_x    = food_x_reg;
    assign food_y    = food_y_reg;
    assign game_over = (state_reg == ST_OVER);
    assign score     = score_reg;
    assign state     = state_reg;

endmodule
